cim_array_sequencer: RTL and testbench

Command-driven sequencer for the 16-row compute-in-memory bitcell macro with dummy cells. It accepts one write, read or compute command at a time over a valid/ready interface and drives the macro's word lines, precharge, sense-amp and ADC enables in fixed phases. It captures `SA_OUT` or the sixteen 4-bit ADC outputs and returns them over a valid/ready response channel. It sits between the host register/bus logic and the macro instance.

---
 rtl/cim_array_sequencer_if.sv | 24 ++
 rtl/cim_array_sequencer.sv | 278 +++++++++++++++++++++++++++
 tb/tb_cim_array_sequencer.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/cim_array_sequencer_if.sv
// Command and response channels between the host bus logic and the CIM array sequencer.
// The host drives through the master modport and the sequencer answers through the slave modport.
interface cim_array_sequencer_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [3:0]  cmd_row;
  logic [15:0] cmd_data;
  logic [15:0] cmd_datab;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [63:0] rsp_data;
  logic        rsp_err;

  modport master (
    output cmd_valid, cmd_op, cmd_row, cmd_data, cmd_datab, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data, rsp_err
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_row, cmd_data, cmd_datab, rsp_ready,
    output cmd_ready, rsp_valid, rsp_data, rsp_err
  );
endinterface

// File: rtl/cim_array_sequencer.sv
// Phase sequencer for the 16-row compute-in-memory macro: one command at a time, registered macro controls.
// Defining CIM_SEQ_STATS_EN adds the stat_ops / stat_err completion counters.
module cim_array_sequencer #(
  parameter int PRE_CYC   = 2,
  parameter int ACT_CYC   = 1,
  parameter int SENSE_CYC = 2
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_i,
  cim_array_sequencer_if.slave bus,
  output logic [15:0]          WWL,
  output logic [15:0]          RWL,
  output logic [15:0]          RWLB,
  output logic [15:0]          Din,
  output logic                 WE,
  output logic                 PRE_SRAM,
  output logic                 PRE_VLSA,
  output logic                 PRE_CLSA,
  output logic                 PRE_A,
  output logic                 SAEN,
  output logic                 VCLP,
  output logic                 EN,
  input  logic [15:0]          SA_OUT,
  input  logic [3:0]           ADC0_OUT,
  input  logic [3:0]           ADC1_OUT,
  input  logic [3:0]           ADC2_OUT,
  input  logic [3:0]           ADC3_OUT,
  input  logic [3:0]           ADC4_OUT,
  input  logic [3:0]           ADC5_OUT,
  input  logic [3:0]           ADC6_OUT,
  input  logic [3:0]           ADC7_OUT,
  input  logic [3:0]           ADC8_OUT,
  input  logic [3:0]           ADC9_OUT,
  input  logic [3:0]           ADC10_OUT,
  input  logic [3:0]           ADC11_OUT,
  input  logic [3:0]           ADC12_OUT,
  input  logic [3:0]           ADC13_OUT,
  input  logic [3:0]           ADC14_OUT,
  input  logic [3:0]           ADC15_OUT
`ifdef CIM_SEQ_STATS_EN
  ,
  output logic [15:0]          stat_ops,
  output logic [7:0]           stat_err
`endif
);

  typedef enum logic [2:0] {IDLE, PRECH, ACT, SENSE, RESP} state_e;

  typedef struct packed {
    logic [15:0] wwl;
    logic [15:0] rwl;
    logic [15:0] rwlb;
    logic [15:0] din;
    logic        we;
    logic        preSram;
    logic        preVlsa;
    logic        preClsa;
    logic        preA;
    logic        saen;
    logic        vclp;
    logic        en;
  } ctl_t;

  localparam logic [1:0] OP_WRITE   = 2'd0;
  localparam logic [1:0] OP_READ    = 2'd1;
  localparam logic [1:0] OP_COMPUTE = 2'd2;

  // Counter holds remaining cycles minus one, so a phase ends when it reads zero.
  localparam logic [3:0] PRE_LOAD   = 4'(PRE_CYC - 1);
  localparam logic [3:0] ACT_LOAD   = 4'(ACT_CYC - 1);
  localparam logic [3:0] SENSE_LOAD = 4'(SENSE_CYC - 1);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [1:0]  op_q, op_d;
  logic [3:0]  row_q, row_d;
  logic [15:0] data_q, data_d;
  logic [15:0] datab_q, datab_d;
  ctl_t        ctl_q, ctl_d;
  logic        rspValid_q, rspValid_d;
  logic        rspErr_q, rspErr_d;
  logic [63:0] rspData_q, rspData_d;

  logic        accept;
  logic [63:0] adcBus;

  assign bus.cmd_ready = (state_q == IDLE) && !wb_rst_i;
  assign accept        = bus.cmd_valid && bus.cmd_ready;

  assign adcBus = {ADC15_OUT, ADC14_OUT, ADC13_OUT, ADC12_OUT,
                   ADC11_OUT, ADC10_OUT, ADC9_OUT,  ADC8_OUT,
                   ADC7_OUT,  ADC6_OUT,  ADC5_OUT,  ADC4_OUT,
                   ADC3_OUT,  ADC2_OUT,  ADC1_OUT,  ADC0_OUT};

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    op_d       = op_q;
    row_d      = row_q;
    data_d     = data_q;
    datab_d    = datab_q;
    rspValid_d = rspValid_q;
    rspErr_d   = rspErr_q;
    rspData_d  = rspData_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          op_d    = bus.cmd_op;
          row_d   = bus.cmd_row;
          data_d  = bus.cmd_data;
          datab_d = bus.cmd_datab;
          case (bus.cmd_op)
            OP_WRITE: begin
              state_d = ACT;
              cnt_d   = ACT_LOAD;
            end
            OP_READ, OP_COMPUTE: begin
              state_d = PRECH;
              cnt_d   = PRE_LOAD;
            end
            default: begin
              state_d    = RESP;
              rspValid_d = 1'b1;
              rspErr_d   = 1'b1;
              rspData_d  = '0;
            end
          endcase
        end
      end
      PRECH: begin
        if (cnt_q == 4'd0) begin
          state_d = ACT;
          cnt_d   = ACT_LOAD;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ACT: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else if (op_q == OP_WRITE) begin
          state_d    = RESP;
          rspValid_d = 1'b1;
          rspErr_d   = 1'b0;
          rspData_d  = '0;
        end else begin
          state_d = SENSE;
          cnt_d   = SENSE_LOAD;
        end
      end
      SENSE: begin
        // The macro result is sampled on the same edge that leaves the sense phase.
        if (cnt_q == 4'd0) begin
          state_d    = RESP;
          rspValid_d = 1'b1;
          rspErr_d   = 1'b0;
          rspData_d  = (op_q == OP_READ) ? {48'd0, SA_OUT} : adcBus;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          state_d    = IDLE;
          rspValid_d = 1'b0;
          rspErr_d   = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Controls are decoded from the phase being entered so the registered pins line up with it.
  always_comb begin
    ctl_d = '0;
    case (state_d)
      PRECH: begin
        ctl_d.preSram = 1'b1;
        if (op_d == OP_READ) begin
          ctl_d.preVlsa = 1'b1;
        end else begin
          ctl_d.preClsa = 1'b1;
          ctl_d.preA    = 1'b1;
        end
      end
      ACT, SENSE: begin
        if (op_d == OP_WRITE) begin
          ctl_d.wwl = 16'd1 << row_d;
          ctl_d.we  = 1'b1;
          ctl_d.din = data_d;
        end else if (op_d == OP_READ) begin
          ctl_d.rwl  = 16'd1 << row_d;
          ctl_d.saen = (state_d == SENSE);
        end else if (op_d == OP_COMPUTE) begin
          ctl_d.rwl  = data_d;
          ctl_d.rwlb = datab_d;
          ctl_d.en   = (state_d == SENSE);
          ctl_d.vclp = (state_d == SENSE);
        end
      end
      default: begin
        ctl_d = '0;
      end
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      op_q       <= OP_WRITE;
      row_q      <= '0;
      data_q     <= '0;
      datab_q    <= '0;
      ctl_q      <= '0;
      rspValid_q <= 1'b0;
      rspErr_q   <= 1'b0;
      rspData_q  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      op_q       <= op_d;
      row_q      <= row_d;
      data_q     <= data_d;
      datab_q    <= datab_d;
      ctl_q      <= ctl_d;
      rspValid_q <= rspValid_d;
      rspErr_q   <= rspErr_d;
      rspData_q  <= rspData_d;
    end
  end

  assign WWL      = ctl_q.wwl;
  assign RWL      = ctl_q.rwl;
  assign RWLB     = ctl_q.rwlb;
  assign Din      = ctl_q.din;
  assign WE       = ctl_q.we;
  assign PRE_SRAM = ctl_q.preSram;
  assign PRE_VLSA = ctl_q.preVlsa;
  assign PRE_CLSA = ctl_q.preClsa;
  assign PRE_A    = ctl_q.preA;
  assign SAEN     = ctl_q.saen;
  assign VCLP     = ctl_q.vclp;
  assign EN       = ctl_q.en;

  assign bus.rsp_valid = rspValid_q;
  assign bus.rsp_err   = rspErr_q;
  assign bus.rsp_data  = rspData_q;

`ifdef CIM_SEQ_STATS_EN
  logic        rspDone;
  logic [15:0] statOps_q;
  logic [7:0]  statErr_q;

  assign rspDone = (state_q == RESP) && bus.rsp_ready;

  // Successful completions wrap; the error tally saturates so it never looks clean again.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      statOps_q <= '0;
      statErr_q <= '0;
    end else if (rspDone) begin
      if (!rspErr_q) begin
        statOps_q <= statOps_q + 16'd1;
      end else if (statErr_q != 8'hFF) begin
        statErr_q <= statErr_q + 8'd1;
      end
    end
  end

  assign stat_ops = statOps_q;
  assign stat_err = statErr_q;
`endif

endmodule

// File: tb/tb_cim_array_sequencer.sv
// Randomized bench for cim_array_sequencer: every command's phase trace and response are predicted
// from phase lengths and op rules, with directed write/read/compute, backpressure, illegal-op and reset cases.
module tb_cim_array_sequencer;
  localparam int PRE = 2;
  localparam int ACT = 1;
  localparam int SEN = 2;

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_i;
  logic [15:0] WWL, RWL, RWLB, Din;
  logic        WE, PRE_SRAM, PRE_VLSA, PRE_CLSA, PRE_A, SAEN, VCLP, EN;
  logic [15:0] saDrv;
  logic [3:0]  adcDrv [16];
`ifdef CIM_SEQ_STATS_EN
  logic [15:0] stat_ops;
  logic [7:0]  stat_err;
`endif

  int          checks = 0;
  int          errors = 0;
  bit          holdSensors;
  logic [15:0] expOps;
  logic [7:0]  expErr;

  always #5 wb_clk_i = ~wb_clk_i;

  cim_array_sequencer_if bus ();

  cim_array_sequencer #(.PRE_CYC(PRE), .ACT_CYC(ACT), .SENSE_CYC(SEN)) dut (
    .wb_clk_i (wb_clk_i),
    .wb_rst_i (wb_rst_i),
    .bus      (bus),
    .WWL      (WWL),
    .RWL      (RWL),
    .RWLB     (RWLB),
    .Din      (Din),
    .WE       (WE),
    .PRE_SRAM (PRE_SRAM),
    .PRE_VLSA (PRE_VLSA),
    .PRE_CLSA (PRE_CLSA),
    .PRE_A    (PRE_A),
    .SAEN     (SAEN),
    .VCLP     (VCLP),
    .EN       (EN),
    .SA_OUT   (saDrv),
    .ADC0_OUT (adcDrv[0]),
    .ADC1_OUT (adcDrv[1]),
    .ADC2_OUT (adcDrv[2]),
    .ADC3_OUT (adcDrv[3]),
    .ADC4_OUT (adcDrv[4]),
    .ADC5_OUT (adcDrv[5]),
    .ADC6_OUT (adcDrv[6]),
    .ADC7_OUT (adcDrv[7]),
    .ADC8_OUT (adcDrv[8]),
    .ADC9_OUT (adcDrv[9]),
    .ADC10_OUT(adcDrv[10]),
    .ADC11_OUT(adcDrv[11]),
    .ADC12_OUT(adcDrv[12]),
    .ADC13_OUT(adcDrv[13]),
    .ADC14_OUT(adcDrv[14]),
    .ADC15_OUT(adcDrv[15])
`ifdef CIM_SEQ_STATS_EN
    ,
    .stat_ops (stat_ops),
    .stat_err (stat_err)
`endif
  );

  task automatic checkOutput(input string tag, input logic [79:0] observed, input logic [79:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  function automatic logic [71:0] ctlObs();
    return {WWL, RWL, RWLB, Din, WE, PRE_SRAM, PRE_VLSA, PRE_CLSA, PRE_A, SAEN, VCLP, EN};
  endfunction

  // Expected macro pins in the k-th cycle after the accept edge (k starts at 1).
  function automatic logic [71:0] expFrame(input int op, input logic [3:0] row,
                                           input logic [15:0] data, input logic [15:0] datab, input int k);
    logic [15:0] wwl, rwl, rwlb, din, oneHot;
    logic        we, preSram, preVlsa, preClsa, preA, saen, vclp, en;
    wwl = '0; rwl = '0; rwlb = '0; din = '0;
    we = 0; preSram = 0; preVlsa = 0; preClsa = 0; preA = 0; saen = 0; vclp = 0; en = 0;
    oneHot = 16'd1 << row;
    if (op == 0) begin
      if (k >= 1 && k <= ACT) begin
        wwl = oneHot; we = 1; din = data;
      end
    end else if (op == 1 || op == 2) begin
      if (k >= 1 && k <= PRE) begin
        preSram = 1;
        if (op == 1) preVlsa = 1;
        else begin preClsa = 1; preA = 1; end
      end else if (k > PRE && k <= PRE + ACT + SEN) begin
        if (op == 1) rwl = oneHot;
        else begin rwl = data; rwlb = datab; end
        if (k > PRE + ACT) begin
          if (op == 1) saen = 1;
          else begin en = 1; vclp = 1; end
        end
      end
    end
    return {wwl, rwl, rwlb, din, we, preSram, preVlsa, preClsa, preA, saen, vclp, en};
  endfunction

  function automatic int latency(input int op);
    if (op == 0) return ACT + 1;
    if (op == 1 || op == 2) return PRE + ACT + SEN + 1;
    return 1;
  endfunction

  task automatic randomizeSensors();
    if (!holdSensors) begin
      saDrv = 16'($urandom);
      for (int i = 0; i < 16; i++) adcDrv[i] = 4'($urandom);
    end
  endtask

  task automatic tick();
    @(posedge wb_clk_i);
    #1;
  endtask

  task automatic scribbleCmd();
    bus.cmd_valid = 1'($urandom);
    bus.cmd_op    = 2'($urandom);
    bus.cmd_row   = 4'($urandom);
    bus.cmd_data  = 16'($urandom);
    bus.cmd_datab = 16'($urandom);
  endtask

  task automatic checkStats();
`ifdef CIM_SEQ_STATS_EN
    checkOutput("stat_ops", 80'(stat_ops), 80'(expOps));
    checkOutput("stat_err", 80'(stat_err), 80'(expErr));
`endif
  endtask

  // One full command from an idle sequencer through the response handshake.
  task automatic applyStimulus(input int op, input logic [3:0] row, input logic [15:0] data,
                               input logic [15:0] datab, input int readyDelay, input bit earlyReady);
    int          lat;
    int          delay;
    logic [15:0] capSa;
    logic [63:0] capAdc;
    logic [63:0] expData;
    lat    = latency(op);
    delay  = earlyReady ? 0 : readyDelay;
    capSa  = '0;
    capAdc = '0;
    checkOutput("idle_cmd_ready", 80'(bus.cmd_ready), 80'd1);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = 2'(op);
    bus.cmd_row   = row;
    bus.cmd_data  = data;
    bus.cmd_datab = datab;
    bus.rsp_ready = earlyReady;
    randomizeSensors();
    tick();
    for (int k = 1; k < lat; k++) begin
      checkOutput($sformatf("phase_ctl_op%0d_k%0d", op, k), 80'(ctlObs()), 80'(expFrame(op, row, data, datab, k)));
      checkOutput("phase_rsp_valid", 80'(bus.rsp_valid), 80'd0);
      checkOutput("phase_cmd_ready", 80'(bus.cmd_ready), 80'd0);
      scribbleCmd();
      randomizeSensors();
      if (k == lat - 1) begin
        capSa = saDrv;
        for (int i = 0; i < 16; i++) capAdc[4*i +: 4] = adcDrv[i];
      end
      tick();
    end
    expData = (op == 1) ? {48'd0, capSa} : (op == 2) ? capAdc : 64'd0;
    for (int d = 0; d <= delay; d++) begin
      checkOutput("rsp_valid", 80'(bus.rsp_valid), 80'd1);
      checkOutput("rsp_data", 80'(bus.rsp_data), 80'(expData));
      checkOutput("rsp_err", 80'(bus.rsp_err), 80'(op == 3));
      checkOutput("rsp_ctl_zero", 80'(ctlObs()), 80'd0);
      checkOutput("rsp_cmd_ready", 80'(bus.cmd_ready), 80'd0);
      scribbleCmd();
      bus.rsp_ready = earlyReady || (d == delay);
      tick();
    end
    bus.cmd_valid = 1'b0;
    bus.rsp_ready = 1'b0;
    if (op == 3) begin
      if (expErr != 8'hFF) expErr = expErr + 8'd1;
    end else begin
      expOps = expOps + 16'd1;
    end
    checkOutput("done_rsp_valid", 80'(bus.rsp_valid), 80'd0);
    checkOutput("done_rsp_err", 80'(bus.rsp_err), 80'd0);
    checkOutput("done_ctl_zero", 80'(ctlObs()), 80'd0);
    checkStats();
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_ctl"}, 80'(ctlObs()), 80'd0);
    checkOutput({tag, "_rsp_valid"}, 80'(bus.rsp_valid), 80'd0);
    checkOutput({tag, "_rsp_err"}, 80'(bus.rsp_err), 80'd0);
    checkOutput({tag, "_rsp_data"}, 80'(bus.rsp_data), 80'd0);
    checkOutput({tag, "_cmd_ready"}, 80'(bus.cmd_ready), 80'd0);
  endtask

  initial begin
    wb_rst_i      = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = '0;
    bus.cmd_row   = '0;
    bus.cmd_data  = '0;
    bus.cmd_datab = '0;
    bus.rsp_ready = 1'b0;
    holdSensors   = 1'b0;
    saDrv         = '0;
    for (int i = 0; i < 16; i++) adcDrv[i] = '0;
    expOps        = '0;
    expErr        = '0;

    tick();
    tick();
    checkResetState("reset");
    checkStats();
    wb_rst_i = 1'b0;
    #1;
    checkOutput("post_reset_cmd_ready", 80'(bus.cmd_ready), 80'd1);
    tick();

    applyStimulus(0, 4'd5, 16'hA5C3, 16'h0000, 0, 1'b0);

    holdSensors = 1'b1;
    saDrv = 16'h1234;
    applyStimulus(1, 4'd15, 16'h0000, 16'h0000, 0, 1'b0);
    for (int i = 0; i < 16; i++) adcDrv[i] = 4'(i);
    applyStimulus(2, 4'd0, 16'h00FF, 16'hFF00, 0, 1'b1);
    holdSensors = 1'b0;

    applyStimulus(1, 4'd3, 16'h0000, 16'h0000, 10, 1'b0);
    applyStimulus(3, 4'd7, 16'hFFFF, 16'hFFFF, 2, 1'b0);

    // Reset lands on the first sense cycle of a read; the response must vanish.
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = 2'd1;
    bus.cmd_row   = 4'd9;
    tick();
    bus.cmd_valid = 1'b0;
    for (int k = 1; k <= PRE + ACT; k++) tick();
    checkOutput("sense_before_reset", 80'(ctlObs()), 80'(expFrame(1, 4'd9, 16'h0, 16'h0, PRE + ACT + 1)));
    wb_rst_i = 1'b1;
    #1;
    checkOutput("rst_cmd_ready", 80'(bus.cmd_ready), 80'd0);
    tick();
    checkResetState("mid_reset");
    expOps = '0;
    expErr = '0;
    checkStats();
    wb_rst_i = 1'b0;
    tick();
    applyStimulus(1, 4'd9, 16'h0000, 16'h0000, 1, 1'b0);

    for (int n = 0; n < 40; n++) begin
      int op;
      bit early;
      op    = int'($urandom_range(0, 3));
      early = 1'($urandom);
      applyStimulus(op, 4'($urandom), 16'($urandom), 16'($urandom),
                    int'($urandom_range(0, 4)), early);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
